// File: rtl/const_tie_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// const_tie_sequencer_pkg
// Shared state encoding and step-counter width for the tie-off sequencer.
// Revision: 1.0
// ============================================================================
package const_tie_sequencer_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_APPLY = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/const_tie_sequencer_step_timer.sv
`default_nettype none
// ============================================================================
// const_seq_step_timer
// Loadable down-counter that saturates at zero and flags when it reads zero.
// Revision: 1.0
// ============================================================================
module const_seq_step_timer
    import const_tie_sequencer_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/const_tie_sequencer.sv
`default_nettype none
// ============================================================================
// const_tie_sequencer
// Releases a bank of constant tie-offs to programmed values one per step.
// Revision: 1.0
// ============================================================================
module const_tie_sequencer
    import const_tie_sequencer_pkg::*;
#(
    parameter int   N_TIES      = 38,
    parameter int   STEP_CYCLES = 4,
    parameter logic DEFAULT_VAL = 1'b0
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      start,
    input  logic                      abort,
    input  logic [N_TIES-1:0]         cfg_value,
    output logic [N_TIES-1:0]         tie_out,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(N_TIES)-1:0] index
);

    localparam int               IDX_W       = $clog2(N_TIES);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_TIES - 1);
    localparam logic [CNT_W-1:0] STEP_RELOAD = CNT_W'(STEP_CYCLES - 1);

    state_e            state_q;
    logic [N_TIES-1:0] shadow_q;
    logic [N_TIES-1:0] tie_q;
    logic [IDX_W-1:0]  index_q;
    logic              busy_q;
    logic              done_q;

    logic              accept;
    logic              last;
    logic              tmr_load;
    logic [CNT_W-1:0]  tmr_val;
    logic              tmr_zero;

    always_comb begin
        accept   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start && !abort;
        last     = (index_q == LAST_IDX);
        tmr_load = 1'b0;
        tmr_val  = '0;
        if (abort) begin
            tmr_load = 1'b1;
        end else if (accept || ((state_q == ST_APPLY) && !last)) begin
            tmr_load = 1'b1;
            tmr_val  = STEP_RELOAD;
        end
    end

    const_seq_step_timer u_step_timer (
        .clock    (clock),
        .resetn   (resetn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            tie_q    <= {N_TIES{DEFAULT_VAL}};
            index_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (abort) begin
            state_q <= ST_IDLE;
            tie_q   <= {N_TIES{DEFAULT_VAL}};
            index_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // Re-sequencing from DONE starts from the ties as they stand.
                    if (start) begin
                        shadow_q <= cfg_value;
                        index_q  <= '0;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (tmr_zero) begin
                        state_q <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    tie_q[index_q] <= shadow_q[index_q];
                    if (last) begin
                        index_q <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        index_q <= index_q + 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign tie_out = tie_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign index   = index_q;

endmodule
`default_nettype wire

// File: tb/tb_const_tie_sequencer.sv
`default_nettype none
// ============================================================================
// tb_const_tie_sequencer
// Scoreboard bench: a 4-tie/4-step instance and a 38-tie/1-step instance.
// Revision: 1.0
// ============================================================================
module tb_const_tie_sequencer;

    logic        clock;
    logic        resetn;

    logic        a_start, a_abort;
    logic [3:0]  a_cfg, a_tie;
    logic        a_busy, a_done;
    logic [1:0]  a_index;

    logic        b_start, b_abort;
    logic [37:0] b_cfg, b_tie;
    logic        b_busy, b_done;
    logic [5:0]  b_index;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          edge_n;
        logic [37:0] tie;
        logic [5:0]  idx;
        logic        busy;
        logic        done;
        bit          chk_idx;
    } exp_t;

    exp_t sb[$];

    const_tie_sequencer #(.N_TIES(4), .STEP_CYCLES(4), .DEFAULT_VAL(1'b0)) u_dut_a (
        .clock     (clock),
        .resetn    (resetn),
        .start     (a_start),
        .abort     (a_abort),
        .cfg_value (a_cfg),
        .tie_out   (a_tie),
        .busy      (a_busy),
        .done      (a_done),
        .index     (a_index)
    );

    const_tie_sequencer #(.N_TIES(38), .STEP_CYCLES(1), .DEFAULT_VAL(1'b0)) u_dut_b (
        .clock     (clock),
        .resetn    (resetn),
        .start     (b_start),
        .abort     (b_abort),
        .cfg_value (b_cfg),
        .tie_out   (b_tie),
        .busy      (b_busy),
        .done      (b_done),
        .index     (b_index)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected outputs after each edge of a sequence whose start was sampled at edge 0.
    task automatic push_seq(input logic [37:0] prev, input logic [37:0] cfg,
                            input int n, input int s);
        int total;
        total = n * (s + 1);
        for (int e = 1; e <= total; e++) begin
            exp_t x;
            x.edge_n = e;
            x.tie    = prev;
            for (int k = 0; k < n; k++) begin
                if (e >= (k + 1) * (s + 1)) x.tie[k] = cfg[k];
            end
            x.busy    = (e < total);
            x.done    = (e >= total);
            x.chk_idx = (e < total);
            x.idx     = 6'(e / (s + 1));
            sb.push_back(x);
        end
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        a_start = 1'b0; a_abort = 1'b0; a_cfg = '0;
        b_start = 1'b0; b_abort = 1'b0; b_cfg = '0;
        #1;
        n_checks++;
        if ({a_tie, a_busy, a_done, a_index} !== 8'b0) $display("FAIL reset_a: got tie=%b busy=%b done=%b idx=%0d required all zero", a_tie, a_busy, a_done, a_index);
        else n_pass++;
        n_checks++;
        if ({b_tie, b_busy, b_done, b_index} !== 46'b0) $display("FAIL reset_b: got tie=%b busy=%b done=%b idx=%0d required all zero", b_tie, b_busy, b_done, b_index);
        else n_pass++;
        repeat (3) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        tick();
        n_checks++;
        if ({a_tie, a_busy, a_done} !== 6'b0) $display("FAIL post_reset_idle: got tie=%b busy=%b done=%b required 0", a_tie, a_busy, a_done);
        else n_pass++;
    endtask

    task automatic test_basic();
        exp_t it;
        int   e;
        sb.delete();
        a_cfg = 4'b1011; a_start = 1'b1;
        push_seq(38'b0, 38'(4'b1011), 4, 4);
        tick();
        a_start = 1'b0;
        n_checks++;
        if (a_busy !== 1'b1 || a_done !== 1'b0) $display("FAIL basic_accept: got busy=%b done=%b required busy=1 done=0", a_busy, a_done);
        else n_pass++;
        e = 0;
        while (sb.size() > 0) begin
            tick(); e++;
            it = sb.pop_front();
            n_checks++;
            if (a_tie !== it.tie[3:0] || a_busy !== it.busy || a_done !== it.done)
                $display("FAIL basic edge %0d: got tie=%b busy=%b done=%b required tie=%b busy=%b done=%b", e, a_tie, a_busy, a_done, it.tie[3:0], it.busy, it.done);
            else n_pass++;
            if (it.chk_idx) begin
                n_checks++;
                if (a_index !== it.idx[1:0]) $display("FAIL basic_index edge %0d: got %0d required %0d", e, a_index, it.idx[1:0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_running_ignored();
        exp_t it;
        int   e;
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        sb.delete();
        a_cfg = 4'b1011; a_start = 1'b1;
        push_seq(38'b0, 38'(4'b1011), 4, 4);
        tick();
        a_start = 1'b0;
        e = 0;
        while (sb.size() > 0) begin
            if (e == 6) begin
                a_cfg = 4'b0000; a_start = 1'b1;
            end else begin
                a_start = 1'b0;
            end
            tick(); e++;
            it = sb.pop_front();
            n_checks++;
            if (a_tie !== it.tie[3:0] || a_done !== it.done)
                $display("FAIL ignored edge %0d: got tie=%b done=%b required tie=%b done=%b", e, a_tie, a_done, it.tie[3:0], it.done);
            else n_pass++;
        end
        a_start = 1'b0;
    endtask

    task automatic test_abort();
        exp_t it;
        int   e;
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        sb.delete();
        a_cfg = 4'b1011; a_start = 1'b1;
        push_seq(38'b0, 38'(4'b1011), 4, 4);
        tick();
        a_start = 1'b0;
        for (e = 1; e <= 12; e++) begin
            tick();
            it = sb.pop_front();
            n_checks++;
            if (a_tie !== it.tie[3:0]) $display("FAIL abort_pre edge %0d: got %b required %b", e, a_tie, it.tie[3:0]);
            else n_pass++;
        end
        sb.delete();
        for (int k = 13; k <= 23; k++) begin
            exp_t x;
            x.edge_n = k; x.tie = '0; x.idx = '0; x.busy = 1'b0; x.done = 1'b0; x.chk_idx = 1'b1;
            sb.push_back(x);
        end
        a_abort = 1'b1; a_start = 1'b1; a_cfg = 4'b1111;
        e = 12;
        while (sb.size() > 0) begin
            tick(); e++;
            a_abort = 1'b0; a_start = 1'b0;
            it = sb.pop_front();
            n_checks++;
            if (a_tie !== it.tie[3:0] || a_busy !== it.busy || a_done !== it.done || a_index !== it.idx[1:0])
                $display("FAIL abort edge %0d: got tie=%b busy=%b done=%b idx=%0d required tie=%b busy=0 done=0 idx=0", e, a_tie, a_busy, a_done, a_index, it.tie[3:0]);
            else n_pass++;
        end
    endtask

    task automatic test_resequence();
        exp_t it;
        int   e;
        sb.delete();
        a_cfg = 4'b1111; a_start = 1'b1;
        push_seq(38'b0, 38'(4'b1111), 4, 4);
        tick();
        a_start = 1'b0;
        while (sb.size() > 0) begin
            tick();
            it = sb.pop_front();
        end
        n_checks++;
        if (a_tie !== 4'b1111 || a_done !== 1'b1) $display("FAIL reseq_first: got tie=%b done=%b required tie=1111 done=1", a_tie, a_done);
        else n_pass++;
        a_cfg = 4'b0101; a_start = 1'b1;
        push_seq(38'(4'b1111), 38'(4'b0101), 4, 4);
        tick();
        a_start = 1'b0;
        e = 0;
        while (sb.size() > 0) begin
            tick(); e++;
            it = sb.pop_front();
            n_checks++;
            if (a_tie !== it.tie[3:0] || a_tie === 4'b0000 || a_done !== it.done)
                $display("FAIL reseq edge %0d: got tie=%b done=%b required tie=%b done=%b", e, a_tie, a_done, it.tie[3:0], it.done);
            else n_pass++;
        end
    endtask

    task automatic test_step1();
        exp_t        it;
        int          e;
        logic [63:0] rnd;
        rnd = {$urandom, $urandom};
        sb.delete();
        b_cfg = rnd[37:0]; b_start = 1'b1;
        push_seq(38'b0, rnd[37:0], 38, 1);
        tick();
        b_start = 1'b0;
        e = 0;
        while (sb.size() > 0) begin
            tick(); e++;
            it = sb.pop_front();
            n_checks++;
            if (b_tie !== it.tie || b_done !== it.done || b_busy !== it.busy)
                $display("FAIL step1 edge %0d: got tie=%h busy=%b done=%b required tie=%h busy=%b done=%b", e, b_tie, b_busy, b_done, it.tie, it.busy, it.done);
            else n_pass++;
            if (it.chk_idx) begin
                n_checks++;
                if (b_index !== it.idx) $display("FAIL step1_index edge %0d: got %0d required %0d", e, b_index, it.idx);
                else n_pass++;
            end
        end
        n_checks++;
        if (e != 76 || b_done !== 1'b1) $display("FAIL step1_done: got done=%b at edge %0d required done=1 at edge 76", b_done, e);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
        a_cfg = 4'b1011; a_start = 1'b1;
        tick();
        a_start = 1'b0;
        repeat (10) tick();
        n_checks++;
        if (a_tie !== 4'b0011) $display("FAIL reset_mid_pre: got %b required 0011", a_tie);
        else n_pass++;
        #2;
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({a_tie, a_busy, a_done, a_index} !== 8'b0) $display("FAIL reset_mid_a: got tie=%b busy=%b done=%b idx=%0d required all zero", a_tie, a_busy, a_done, a_index);
        else n_pass++;
        n_checks++;
        if ({b_tie, b_done} !== 39'b0) $display("FAIL reset_mid_b: got tie=%h done=%b required all zero", b_tie, b_done);
        else n_pass++;
        @(negedge clock);
        resetn = 1'b1;
        repeat (6) tick();
        n_checks++;
        if ({a_tie, a_busy, a_done} !== 6'b0) $display("FAIL reset_mid_after: got tie=%b busy=%b done=%b required 0", a_tie, a_busy, a_done);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_running_ignored();
        test_abort();
        test_resequence();
        test_step1();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
